lfsr_bank: RTL
==============

# lfsr_bank

Multi-channel pseudo-random source that generalises the single 32-bit Fibonacci LFSR. It provides N_CH independent channels sharing a runtime-programmable tap mask, and each channel can be reseeded on its own. A channel can advance several bits per enable (leap-forward), and all-zero lock-up is detected and recovered automatically. It feeds the stochastic/dither consumers in the datapath with one registered OUT_WID-bit word per channel.

## Interface
- WIDTH, 32: LFSR state width per channel (≥4).
- OUT_WID, 6: output bits per channel (1..WIDTH); taken from state[WIDTH-1 -: OUT_WID].
- N_CH, 4: number of channels (1..16).
- STEPS, 1: shifts applied per enabled cycle (1..WIDTH).
- DEFAULT_TAPS, 32'h8020_0003: reset tap mask (bits 31, 21, 1, 0).
- DEFAULT_SEED, 1: reset seed base; must be non-zero.

- clk  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  advance all channels by STEPS this cycle.
- seed_we_i  in  1  write seed_i into channel seed_ch_i.
- seed_ch_i  in  $clog2(N_CH) (min 1)  target channel; values ≥N_CH are ignored.
- seed_i  in  WIDTH  seed value.
- taps_we_i  in  1  write taps_i into the shared tap mask.
- taps_i  in  WIDTH  tap mask.
- lockup_clr_i  in  1  clear all sticky lockup flags.
- rand_o  out  N_CH*OUT_WID  channel c occupies bits [c*OUT_WID +: OUT_WID].
- valid_o  out  1  rand_o was updated by an enable last cycle.
- lockup_o  out  N_CH  sticky per-channel lock-up flag.

## Operation
- Single shift: next = {s[WIDTH-2:0], ^(s & taps)}. An enable applies this STEPS times combinationally, so the result equals STEPS sequential single shifts.
- Reset (async assert, sync-safe deassert per team practice) sets:
  - state[c] = DEFAULT_SEED rotated left by c (mod WIDTH)
  - taps = DEFAULT_TAPS
  - rand_o = 0, valid_o = 0, lockup_o = 0.
- Per-channel update priority each cycle, highest first:
  1. Seed write to that channel: state ← seed_i.
  2. Lock-up recovery, when state == 0: state ← the channel's reset seed and lockup_o[c] ← 1.
  3. en_i: state ← STEPS-shift of state using the current (pre-write) tap mask.
  4. Otherwise hold.
- A seed write of 0 is stored as given. Recovery happens on the following cycle.
- Lock-up check runs every cycle, independent of en_i.
- Tap write takes effect from the next cycle. An en_i in the same cycle uses the old mask.
- Tap mask 0 is legal. Channels then shift in zeros and hit recovery after at most WIDTH shifts.
- Output:
  - When en_i: rand_o[c] ← top OUT_WID bits of the state channel c holds after this cycle's update (seeded, recovered or advanced), and valid_o ← 1.
  - When !en_i: rand_o holds and valid_o ← 0.
- lockup_clr_i clears lockup_o. If clear and a new lock-up occur in the same cycle, set wins.
- Channels never interact except through the shared tap mask.

## Timing
- Latency: state and rand_o both update on the edge that samples en_i, so valid_o and the new rand_o are visible 1 cycle after en_i.
- Throughput: one STEPS-advance per cycle, sustained en_i allowed.
- Seed-to-use: a seed written at cycle t is the state at t+1. With en_i at t+1, the output at t+2 reflects seed advanced by STEPS.
- Simultaneous seed write and en_i on the same channel: the seed wins, the channel does not advance, and rand_o shows the seed's top bits.
- Reset mid-stream: all outputs return to reset values asynchronously. No partial update is retained.

## Test plan
- Reset, then 3 enables with defaults (WIDTH=32, STEPS=1):
  - ch0 state sequence is 0x1 → 0x3 → 0x6 → 0xD.
  - ch1 starts at 0x2.
  - rand_o stays 0 and valid_o is high for exactly 3 cycles, each 1 cycle after its en_i.
- Seed ch2 = 0x8000_0000 with en_i in the same cycle:
  - rand_o[ch2] = 6'b100000.
  - The next enable gives state 0x0000_0001, since feedback = bit31 = 1.
- STEPS=4 build, 1000 random enables/seeds: every channel's state matches a model applying 4 single shifts per enable.
- taps_i = 0 after seeding ch0 = 0x1, then sustained en_i:
  - state reaches 0 after 32 shifts.
  - The next cycle reloads 0x1 and sets lockup_o[0].
  - lockup_clr_i clears the flag.
- Write seed 0 to ch1 with no enable:
  - one cycle later ch1 state = 0x2 and lockup_o[1] = 1.
  - lockup_clr_i in that same recovery cycle still leaves the flag at 1.
- Assert rst_ni low asynchronously mid-run (between edges) while en_i is high:
  - outputs go to 0 immediately.
  - after release, the sequence restarts from the reset seeds.

Source files
------------

// File: rtl/lfsr_bank.sv
// Bank of independent Fibonacci LFSR channels with a shared runtime tap mask.
// Supports per-channel reseed, multi-step advance and all-zero lock-up recovery.
module lfsr_bank #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      OUT_WID      = 6,
  parameter int unsigned      N_CH         = 4,
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  localparam int unsigned     CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    seed_we_i,
  input  logic [CH_W-1:0]         seed_ch_i,
  input  logic [WIDTH-1:0]        seed_i,
  input  logic                    taps_we_i,
  input  logic [WIDTH-1:0]        taps_i,
  input  logic                    lockup_clr_i,
  output logic [N_CH*OUT_WID-1:0] rand_o,
  output logic                    valid_o,
  output logic [N_CH-1:0]         lockup_o
);

  logic [WIDTH-1:0]             taps_q;
  logic [N_CH-1:0][WIDTH-1:0]   state_q;
  logic [N_CH-1:0][WIDTH-1:0]   state_d;
  logic [N_CH-1:0]              lock_set;
  logic [N_CH*OUT_WID-1:0]      rand_q;
  logic                         valid_q;
  logic [N_CH-1:0]              lockup_q;

  // Each channel's reset seed is the base seed rotated left by its index.
  function automatic logic [WIDTH-1:0] reset_seed(input int unsigned c);
    int unsigned      r;
    logic [WIDTH-1:0] v;
    r = c % WIDTH;
    v = DEFAULT_SEED;
    return (v << r) | (v >> (WIDTH - r));
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] v;
    v = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      v = {v[WIDTH-2:0], ^(v & t)};
    end
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    lock_set = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (seed_we_i && (32'(seed_ch_i) == c)) begin
        state_d[c] = seed_i;
      end else if (state_q[c] == '0) begin
        state_d[c]  = reset_seed(c);
        lock_set[c] = 1'b1;
      end else if (en_i) begin
        state_d[c] = advance(state_q[c], taps_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        state_q[c] <= reset_seed(c);
      end
      taps_q   <= DEFAULT_TAPS;
      rand_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= '0;
    end else begin
      state_q <= state_d;
      if (taps_we_i) begin
        taps_q <= taps_i;
      end
      valid_q <= en_i;
      if (en_i) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          rand_q[c*OUT_WID +: OUT_WID] <= state_d[c][WIDTH-1 -: OUT_WID];
        end
      end
      // A new lock-up in the same cycle as a clear keeps the flag set.
      lockup_q <= (lockup_q & ~{N_CH{lockup_clr_i}}) | lock_set;
    end
  end

  assign rand_o   = rand_q;
  assign valid_o  = valid_q;
  assign lockup_o = lockup_q;

endmodule
